// File: rtl/regfile_operand_fetch_pkg.sv
// Shared definitions for the register-file operand fetch block: default sizing
// and the fetch FSM state encoding used by every register_file initiator.
package regfile_operand_fetch_pkg;

    localparam int DEF_N_REGS    = 8;
    localparam int DEF_REG_WIDTH = 8;
    localparam int DEF_CNT_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_CAP_B = 3'd3,
        S_RESP  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Decode-side bundle of the operand fetch block: request, response and
// writeback channels. The decode stage is the master, the fetch block the slave.
interface regfile_operand_fetch_if
    import regfile_operand_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = $clog2(DEF_N_REGS),
    parameter int REG_WIDTH  = DEF_REG_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_rs1;
    logic [ADDR_WIDTH-1:0] req_rs2;
    logic                  req_use_rs2;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [REG_WIDTH-1:0]  rsp_op_a;
    logic [REG_WIDTH-1:0]  rsp_op_b;

    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_idx;
    logic [REG_WIDTH-1:0]  wb_data;

    modport master (
        output req_valid, req_rs1, req_rs2, req_use_rs2,
        input  req_ready,
        input  rsp_valid, rsp_op_a, rsp_op_b,
        output rsp_ready,
        output wb_valid, wb_idx, wb_data
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_use_rs2,
        output req_ready,
        output rsp_valid, rsp_op_a, rsp_op_b,
        input  rsp_ready,
        input  wb_valid, wb_idx, wb_data
    );

endinterface

// File: rtl/regfile_operand_fetch_rf_reset_gen.sv
// Reset generator for the register_file: asserts together with reset_n and
// releases on the first clock edge afterwards, so the file always sees a reset edge.
module rf_reset_gen (
    input  logic clk,
    input  logic reset_n,
    output logic rf_reset
);

    logic rf_reset_r;

    // Async assert, synchronous release on the first edge with reset_n high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_reset_r <= 1'b1;
        end else begin
            rf_reset_r <= 1'b0;
        end
    end

    assign rf_reset = rf_reset_r;

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch initiator for a single-read-port register_file: sequences the
// rs1/rs2 reads around writebacks, which always win the port, and counts stalls.
module regfile_operand_fetch
    import regfile_operand_fetch_pkg::*;
#(
    parameter int N_REGS     = DEF_N_REGS,
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int ADDR_WIDTH = $clog2(N_REGS),
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_operand_fetch_if.slave fetch,
    output logic                   rf_reset,
    output logic                   rf_write_enable,
    output logic [ADDR_WIDTH-1:0]  rf_wreg_index,
    output logic [REG_WIDTH-1:0]   rf_data_in,
    output logic [ADDR_WIDTH-1:0]  rf_rreg_index,
    input  logic [REG_WIDTH-1:0]   rf_data_out,
    output logic [CNT_WIDTH-1:0]   stall_cycles
);

    fetch_state_e          state_r;
    fetch_state_e          state_next_s;
    logic [ADDR_WIDTH-1:0] rs1_r;
    logic [ADDR_WIDTH-1:0] rs1_next_s;
    logic [ADDR_WIDTH-1:0] rs2_r;
    logic [ADDR_WIDTH-1:0] rs2_next_s;
    logic                  use_rs2_r;
    logic                  use_rs2_next_s;
    logic [REG_WIDTH-1:0]  op_a_r;
    logic [REG_WIDTH-1:0]  op_a_next_s;
    logic [REG_WIDTH-1:0]  op_b_r;
    logic [REG_WIDTH-1:0]  op_b_next_s;
    logic [CNT_WIDTH-1:0]  stall_r;
    logic [CNT_WIDTH-1:0]  stall_next_s;
    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic [ADDR_WIDTH-1:0] rreg_index_r;
    logic                  rf_reset_s;
    logic                  wb_live_s;
    logic                  accept_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (&value) begin
            sat_inc = value;
        end else begin
            sat_inc = value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    rf_reset_gen u_rf_reset_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .rf_reset (rf_reset_s)
    );

    // Writebacks arriving while the register_file is still in reset are dropped.
    always_comb begin
        wb_live_s = fetch.wb_valid & ~rf_reset_s;
        accept_s  = fetch.req_valid & req_ready_r;
    end

    // Next-state and datapath updates for the fetch sequence.
    always_comb begin
        state_next_s   = state_r;
        rs1_next_s     = rs1_r;
        rs2_next_s     = rs2_r;
        use_rs2_next_s = use_rs2_r;
        op_a_next_s    = op_a_r;
        op_b_next_s    = op_b_r;
        stall_next_s   = stall_r;

        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    rs1_next_s     = fetch.req_rs1;
                    rs2_next_s     = fetch.req_rs2;
                    use_rs2_next_s = fetch.req_use_rs2;
                    state_next_s   = S_RD_A;
                end else begin
                    state_next_s   = S_IDLE;
                end
            end
            S_RD_A: begin
                if (wb_live_s) begin
                    stall_next_s = sat_inc(stall_r);
                end else begin
                    state_next_s = S_RD_B;
                end
            end
            S_RD_B: begin
                // The file holds data_out while writes suppress its read, so
                // recapturing operand A here every cycle is harmless.
                op_a_next_s = rf_data_out;
                if (wb_live_s) begin
                    stall_next_s = sat_inc(stall_r);
                end else begin
                    stall_next_s = stall_r;
                end
                if (!use_rs2_r) begin
                    op_b_next_s  = {REG_WIDTH{1'b0}};
                    state_next_s = S_RESP;
                end else if (wb_live_s) begin
                    state_next_s = S_RD_B;
                end else begin
                    state_next_s = S_CAP_B;
                end
            end
            S_CAP_B: begin
                op_b_next_s  = rf_data_out;
                state_next_s = S_RESP;
            end
            S_RESP: begin
                if (fetch.rsp_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, operand, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            rs1_r        <= {ADDR_WIDTH{1'b0}};
            rs2_r        <= {ADDR_WIDTH{1'b0}};
            use_rs2_r    <= 1'b0;
            op_a_r       <= {REG_WIDTH{1'b0}};
            op_b_r       <= {REG_WIDTH{1'b0}};
            stall_r      <= {CNT_WIDTH{1'b0}};
            req_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rreg_index_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r      <= state_next_s;
            rs1_r        <= rs1_next_s;
            rs2_r        <= rs2_next_s;
            use_rs2_r    <= use_rs2_next_s;
            op_a_r       <= op_a_next_s;
            op_b_r       <= op_b_next_s;
            stall_r      <= stall_next_s;
            // rf_reset is always clear after any edge with reset_n high, so
            // readiness only depends on where the FSM is heading.
            req_ready_r  <= (state_next_s == S_IDLE);
            rsp_valid_r  <= (state_next_s == S_RESP);
            if (state_next_s == S_RD_A) begin
                rreg_index_r <= rs1_next_s;
            end else begin
                rreg_index_r <= rs2_next_s;
            end
        end
    end

    assign fetch.req_ready = req_ready_r;
    assign fetch.rsp_valid = rsp_valid_r;
    assign fetch.rsp_op_a  = op_a_r;
    assign fetch.rsp_op_b  = op_b_r;

    assign rf_reset        = rf_reset_s;
    assign rf_write_enable = wb_live_s;
    assign rf_wreg_index   = fetch.wb_idx;
    assign rf_data_in      = fetch.wb_data;
    assign rf_rreg_index   = rreg_index_r;
    assign stall_cycles    = stall_r;

endmodule
